// File: rtl/cnt_arbiter.sv
// Round-robin arbiter/sequencer sharing one 8-bit presettable counter chain among NREQ requesters.
// Define CNT_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module cnt_arbiter #(
    parameter int unsigned NREQ = 4
) (
    input  logic              clk_i,
    input  logic              clr_i,
    input  logic [NREQ-1:0]   req_i,
    input  logic [8*NREQ-1:0] len_i,
    output logic [NREQ-1:0]   gnt_o,
    output logic [NREQ-1:0]   done_o,
    output logic              busy_o,
    output logic [7:0]        cnt_d_o,
    output logic              cnt_load_n_o,
    output logic              cnt_enp_o,
    output logic              cnt_ent_o,
    input  logic              cnt_rco_i
);

    localparam int unsigned IdxW = $clog2(NREQ);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [IdxW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [7:0]        cnt_d_q, cnt_d_d;

    logic              any_req;
    logic [IdxW-1:0]   win_idx;
    logic [7:0]        win_len;

    // Winner selection; loops run from lowest to highest priority so the last hit wins.
    always_comb begin
        any_req = |req_i;
        win_idx = '0;
`ifdef CNT_ARB_FIXED_PRIO_EN
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_i[IdxW'(i)]) begin
                win_idx = IdxW'(i);
            end
        end
`else
        for (int unsigned off = NREQ; off >= 1; off--) begin
            int unsigned cand;
            cand = (int'(ptr_q) + off) % NREQ;
            if (req_i[IdxW'(cand)]) begin
                win_idx = IdxW'(cand);
            end
        end
`endif
    end

    assign win_len = len_i[{win_idx, 3'b000} +: 8];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        cnt_d_d = cnt_d_q;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d = StLoad;
                    idx_d   = win_idx;
                    ptr_d   = win_idx;
                    gnt_d   = {{(NREQ - 1){1'b0}}, 1'b1} << win_idx;
                    // Counting from ~LEN (= 255-LEN) up to 8'hFF spans LEN+1 enabled cycles.
                    cnt_d_d = ~win_len;
                end
            end
            StLoad: begin
                if (!req_i[idx_q]) begin
                    state_d = StIdle;
                    gnt_d   = '0;
                end else begin
                    state_d = StRun;
                end
            end
            StRun: begin
                // Abort wins over a coincident ripple-carry.
                if (!req_i[idx_q]) begin
                    state_d = StIdle;
                    gnt_d   = '0;
                end else if (cnt_rco_i) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
                gnt_d   = '0;
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            state_q <= StIdle;
            idx_q   <= '0;
            ptr_q   <= IdxW'(NREQ - 1);
            gnt_q   <= '0;
            cnt_d_q <= 8'h00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            cnt_d_q <= cnt_d_d;
        end
    end

    assign gnt_o        = gnt_q;
    assign done_o       = (state_q == StDone) ? gnt_q : '0;
    assign busy_o       = (state_q != StIdle);
    assign cnt_d_o      = cnt_d_q;
    assign cnt_load_n_o = (state_q != StLoad);
    assign cnt_enp_o    = (state_q == StRun);
    assign cnt_ent_o    = (state_q == StRun);

endmodule

// File: doc/cnt_arbiter.md
# cnt_arbiter

Round-robin arbiter and sequencer that shares one 8-bit presettable up-counter among NREQ requesters. The counter is two cascaded 4-bit synchronous counter stages; the lower-stage ripple-carry output gates the upper stage's ENT. Each requester asks for a delay of LEN count cycles. The arbiter grants the counter, loads the preset, enables counting, watches the ripple-carry output, and pulses DONE back to the winner.

## Interface
- NREQ, 4, number of requesters (legal 2..8)
- CLK  in  1  clock, rising edge
- CLR  in  1  asynchronous active-high reset
- REQ  in  NREQ  request per requester; held high until DONE, dropping it aborts
- LEN  in  8*NREQ  delay per requester; slot i at [8i+7:8i]; sampled only at grant
- GNT  out  NREQ  one-hot grant, high from LOAD through DONE
- DONE  out  NREQ  one-cycle completion pulse for the granted requester
- BUSY  out  1  high whenever state is not IDLE
- CNT_D  out  8  preset to the counter chain
- CNT_LOAD_n  out  1  active-low synchronous load to both stages
- CNT_ENP  out  1  count enable (parallel) to both stages
- CNT_ENT  out  1  count enable (trickle) to the lower stage
- CNT_RCO  in  1  upper-stage ripple-carry (high when Q==8'hFF and the chain is enabled)

## Operation
- FSM states: IDLE, LOAD, RUN, DONE. All outputs are Moore-decoded from registered state and registers.
- IDLE:
  - If any REQ is high, select a winner idx and go to LOAD.
  - Latch CNT_D = ~LEN[idx], which equals 255-LEN.
  - Register the one-hot GNT.
- LOAD: CNT_LOAD_n=0, CNT_ENP=CNT_ENT=0. Next state is RUN.
- RUN:
  - CNT_ENP=CNT_ENT=1.
  - If REQ[idx]==0, go to IDLE. This is an abort: GNT clears and no DONE is issued.
  - Otherwise, if CNT_RCO==1, go to DONE.
  - Abort takes precedence over CNT_RCO in the same cycle.
  - An abort in LOAD behaves the same way: next state is IDLE.
- DONE: DONE[idx]=1, GNT held, enables low. Next state is IDLE and GNT clears.
- Arbitration:
  - Round-robin pointer ptr holds the last granted index.
  - Search order is ptr+1, ptr+2, … modulo NREQ.
  - ptr updates on every grant, including grants that are later aborted.
- Requests arriving while BUSY wait; they do not pre-empt.
- A requester still holding REQ in IDLE after its own DONE is treated as a new request and arbitrated normally.
- Counter arithmetic: the counter counts from 255-LEN up to 8'hFF.
  - LEN=0 loads 8'hFF, so CNT_RCO is high in the first RUN cycle.
  - The counter wraps to 8'h00 on the last RUN edge. This block does not clear it.
- Reset (CLR=1, asynchronous, including mid-job):
  - state=IDLE, ptr=NREQ-1 (requester 0 first), GNT=0, DONE=0, BUSY=0.
  - CNT_LOAD_n=1, CNT_ENP=0, CNT_ENT=0, CNT_D=8'h00.

## Timing
- Cycle numbering: cycle 0 is IDLE with REQ sampled high.
- Cycle 1 is LOAD. RUN occupies cycles 2..LEN+2 (LEN+1 cycles). DONE pulses in cycle LEN+3. The FSM is back in IDLE in cycle LEN+4.
- Per-job occupancy is LEN+4 cycles, including the IDLE arbitration cycle.
- GNT rises at cycle 1 and falls after cycle LEN+3.
- Abort latency: REQ low sampled in cycle k (LOAD/RUN) gives IDLE, with GNT and enables low, in cycle k+1.

## Configuration
- CNT_ARB_FIXED_PRIO_EN defined: fixed priority; the lowest-index active REQ wins and ptr is unused.
- CNT_ARB_FIXED_PRIO_EN undefined (default): round-robin as above.

## Test plan
All scenarios use a bench model of two cascaded 4-bit presettable counters.

- REQ[0]=1, LEN0=3 from cycle 0:
  - CNT_LOAD_n=0 with CNT_D=8'hFC in cycle 1.
  - Enables high in cycles 2..5.
  - DONE[0] pulse in cycle 6, BUSY low in cycle 7.
- LEN0=0, then LEN0=255:
  - For LEN0=0: CNT_D=8'hFF, RUN lasts 1 cycle, DONE in cycle 3.
  - For LEN0=255: CNT_D=8'h00, RUN lasts 256 cycles, DONE in cycle 258.
- REQ=4'b1111, all LEN=1, each REQ dropped after its DONE:
  - Grants come in order 0,1,2,3, 5 cycles apart.
  - Repeat with REQ[0] re-raised right after DONE[0]. Round-robin grants 1 next; with CNT_ARB_FIXED_PRIO_EN, 0 is re-granted.
- REQ[2] alone, LEN=10, REQ[2] dropped in cycle 4 (RUN):
  - Cycle 5 is IDLE with GNT=0 and enables low.
  - No DONE pulse; the next grant search starts at 3.
- CLR pulsed high mid-RUN, between clock edges:
  - All outputs reach their reset values immediately, without waiting for an edge.
  - After release, REQ[1]|REQ[3] grants 1 first.
